// File: rtl/phase_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer_ctrl
// Purpose  : Run/halt/single-step sequencer for the CPU's multi-phase
//            instruction timing. Each phase lasts Divisor+1 clocks. The final
//            phase of an instruction comes from the decoder (LastPhase). A phase
//            can be held in STALL while memory is not ready.
// Ports    : PLClock, Reset           - clock, synchronous active-high reset
//            Run, HaltReq, StepMode,  - run control (levels); Step is a
//            Step                       1-cycle single-step pulse
//            Divisor                  - phase period = Divisor+1 clocks
//            LastPhase                - final phase of current instruction
//            MemWaitMask, MemReady    - per-phase memory wait-state gating
//            PhaseIndex/PhaseOneHot   - current phase (one-hot zero when idle)
//            ClockSource              - legacy thermometer phase output
//            PhaseTick, InstrDone     - phase-start / instruction-end strobes
//            Running, Halted          - status
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer_ctrl #(
    parameter int NUM_PHASES = 5,
    parameter int DIV_WIDTH  = 4,
    parameter int PH_W       = 3
) (
    input  logic                  PLClock,
    input  logic                  Reset,
    input  logic                  Run,
    input  logic                  HaltReq,
    input  logic                  StepMode,
    input  logic                  Step,
    input  logic [DIV_WIDTH-1:0]  Divisor,
    input  logic [PH_W-1:0]       LastPhase,
    input  logic [NUM_PHASES-1:0] MemWaitMask,
    input  logic                  MemReady,
    output logic [PH_W-1:0]       PhaseIndex,
    output logic [NUM_PHASES-1:0] PhaseOneHot,
    output logic [NUM_PHASES-2:0] ClockSource,
    output logic                  PhaseTick,
    output logic                  InstrDone,
    output logic                  Running,
    output logic                  Halted
);

    localparam logic [PH_W-1:0] c_MAX_PHASE = PH_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STALL  = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t                r_state;
    logic [PH_W-1:0]       r_phase;
    logic [DIV_WIDTH-1:0]  r_count;
    logic                  r_single;   // current instruction was started by Step
    logic                  r_tick;
    logic [NUM_PHASES-1:0] r_onehot;
    logic [NUM_PHASES-2:0] r_therm;
    logic                  r_running;
    logic                  r_halted;

    logic [PH_W-1:0]       w_eff_last;
    logic                  w_at_point;
    logic                  w_wait;
    logic                  w_advance;
    logic                  w_boundary;

    state_t                w_next_state;
    logic [PH_W-1:0]       w_next_phase;
    logic [DIV_WIDTH-1:0]  w_next_count;
    logic                  w_next_single;
    logic                  w_next_tick;
    logic                  w_next_active;
    logic [NUM_PHASES-1:0] w_next_onehot;
    logic [NUM_PHASES-2:0] w_next_therm;

    // Decoder may report a phase beyond the implemented range; clamp it.
    assign w_eff_last = (LastPhase > c_MAX_PHASE) ? c_MAX_PHASE : LastPhase;

    // >= rather than == so that lowering Divisor below the running count
    // ends the phase at once instead of waiting for the counter to wrap.
    assign w_at_point = (r_state == S_ACTIVE) && (r_count >= Divisor);

    // r_onehot is the decoded current phase whenever the sequencer is ACTIVE.
    assign w_wait     = (|(MemWaitMask & r_onehot)) && !MemReady;

    // In STALL the divider already sits at its terminal count, so the first
    // cycle with MemReady=1 is itself the advance cycle.
    assign w_advance  = (w_at_point && !w_wait) ||
                        ((r_state == S_STALL) && MemReady);
    assign w_boundary = w_advance && (r_phase >= w_eff_last);

    always_comb begin
        w_next_state  = r_state;
        w_next_phase  = r_phase;
        w_next_count  = r_count;
        w_next_single = r_single;
        w_next_tick   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) begin
                    w_next_state = S_ACTIVE;
                    w_next_phase = '0;
                    w_next_count = '0;
                    w_next_tick  = 1'b1;
                end
            end
            S_HALT: begin
                // Halt request overrides both Step and Run.
                if (HaltReq) begin
                    w_next_state = S_HALT;
                end else if (Step) begin
                    w_next_state  = S_ACTIVE;
                    w_next_phase  = '0;
                    w_next_count  = '0;
                    w_next_single = 1'b1;
                    w_next_tick   = 1'b1;
                end else if (Run && !StepMode) begin
                    w_next_state  = S_ACTIVE;
                    w_next_phase  = '0;
                    w_next_count  = '0;
                    w_next_single = 1'b0;
                    w_next_tick   = 1'b1;
                end
            end
            S_ACTIVE, S_STALL: begin
                if (w_advance) begin
                    w_next_count = '0;
                    if (w_boundary) begin
                        w_next_phase  = '0;
                        w_next_single = 1'b0;
                        if (HaltReq || StepMode || r_single) begin
                            w_next_state = S_HALT;
                        end else begin
                            w_next_state = S_ACTIVE;
                            w_next_tick  = 1'b1;
                        end
                    end else begin
                        w_next_state = S_ACTIVE;
                        w_next_phase = r_phase + PH_W'(1);
                        w_next_tick  = 1'b1;
                    end
                end else if (r_state == S_ACTIVE) begin
                    if (w_at_point) begin
                        // Memory not ready: hold phase and terminal count.
                        w_next_state = S_STALL;
                    end else begin
                        w_next_count = r_count + DIV_WIDTH'(1);
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_phase = '0;
                w_next_count = '0;
            end
        endcase
    end

    assign w_next_active = (w_next_state == S_ACTIVE) || (w_next_state == S_STALL);

    always_comb begin
        w_next_onehot = '0;
        w_next_therm  = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (w_next_active && (w_next_phase == PH_W'(k))) begin
                w_next_onehot[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_PHASES - 1; k++) begin
            if (w_next_active && (w_next_phase > PH_W'(k))) begin
                w_next_therm[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge PLClock) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_count   <= '0;
            r_single  <= 1'b0;
            r_tick    <= 1'b0;
            r_onehot  <= '0;
            r_therm   <= '0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_phase   <= w_next_phase;
            r_count   <= w_next_count;
            r_single  <= w_next_single;
            r_tick    <= w_next_tick;
            r_onehot  <= w_next_onehot;
            r_therm   <= w_next_therm;
            r_running <= w_next_active;
            r_halted  <= (w_next_state == S_HALT);
        end
    end

    assign PhaseIndex  = r_phase;
    assign PhaseOneHot = r_onehot;
    assign ClockSource = r_therm;
    assign PhaseTick   = r_tick;
    // The instruction ends on the advance cycle itself; a reset in that cycle
    // aborts the instruction instead.
    assign InstrDone   = w_boundary && !Reset;
    assign Running     = r_running;
    assign Halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer_ctrl
// Purpose  : Self-checking bench for phase_sequencer_ctrl: directed vector
//            table, hand-written multi-cycle sequences, and randomized
//            stimulus compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer_ctrl;

    localparam int NP = 5;

    logic          PLClock = 1'b0;
    logic          Reset, Run, HaltReq, StepMode, Step, MemReady;
    logic [3:0]    Divisor;
    logic [2:0]    LastPhase;
    logic [NP-1:0] MemWaitMask;
    logic [2:0]    PhaseIndex;
    logic [NP-1:0] PhaseOneHot;
    logic [NP-2:0] ClockSource;
    logic          PhaseTick, InstrDone, Running, Halted;

    int tests = 0;
    int fails = 0;

    phase_sequencer_ctrl #(.NUM_PHASES(NP), .DIV_WIDTH(4), .PH_W(3)) dut (
        .PLClock(PLClock), .Reset(Reset), .Run(Run), .HaltReq(HaltReq),
        .StepMode(StepMode), .Step(Step), .Divisor(Divisor),
        .LastPhase(LastPhase), .MemWaitMask(MemWaitMask), .MemReady(MemReady),
        .PhaseIndex(PhaseIndex), .PhaseOneHot(PhaseOneHot),
        .ClockSource(ClockSource), .PhaseTick(PhaseTick),
        .InstrDone(InstrDone), .Running(Running), .Halted(Halted)
    );

    always #5 PLClock = ~PLClock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge PLClock);
        #1;
    endtask

    task automatic settle();
        @(negedge PLClock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       run;
        logic [3:0] div;
        logic [2:0] last;
        int         e_ph;
        logic [3:0] e_cs;
        logic       e_tick;
        logic       e_done;
        logic       e_run;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic run, input int div, input int last,
                       input int ph, input int cs, input logic tk, input logic dn, input logic rn);
        vec_t v;
        v.rst = rst; v.run = run; v.div = 4'(div); v.last = 3'(last);
        v.e_ph = ph; v.e_cs = 4'(cs); v.e_tick = tk; v.e_done = dn; v.e_run = rn;
        vq.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    int m_phase = 0, m_elapsed = 0;
    bit m_run = 0, m_halt = 0, m_stall = 0, m_single = 0, m_fresh = 0;
    bit model_on = 0;

    task automatic model_step();
        int         eff;
        bit         go;
        bit         done;
        logic [NP-1:0] e_oh;
        logic [3:0] e_cs;
        eff  = (int'(LastPhase) > NP - 1) ? NP - 1 : int'(LastPhase);
        go   = 0;
        if (m_run) begin
            if (m_stall) go = MemReady;
            else go = (m_elapsed >= int'(Divisor)) && !(MemWaitMask[m_phase] && !MemReady);
        end
        done = go && (m_phase >= eff) && !Reset;
        e_oh = m_run ? (NP'(1) << m_phase) : '0;
        e_cs = m_run ? 4'((1 << m_phase) - 1) : 4'd0;
        if (model_on) begin
            tests++;
            if ({PhaseIndex, PhaseOneHot, ClockSource, PhaseTick, InstrDone, Running, Halted} !==
                {3'(m_phase), e_oh, e_cs, m_fresh, done, m_run, m_halt}) begin
                fails++;
                $display("FAIL random_model: got ph=%0d oh=%b cs=%b tick=%b done=%b run=%b halt=%b want ph=%0d oh=%b cs=%b tick=%b done=%b run=%b halt=%b",
                         PhaseIndex, PhaseOneHot, ClockSource, PhaseTick, InstrDone, Running, Halted,
                         m_phase, e_oh, e_cs, m_fresh, done, m_run, m_halt);
            end
        end
        m_fresh = 0;
        if (Reset) begin
            m_phase = 0; m_elapsed = 0; m_run = 0; m_halt = 0; m_stall = 0; m_single = 0;
        end else if (m_run) begin
            if (go) begin
                m_stall = 0; m_elapsed = 0;
                if (m_phase < eff) begin
                    m_phase++; m_fresh = 1;
                end else begin
                    m_phase = 0;
                    if (HaltReq || StepMode || m_single) begin
                        m_run = 0; m_halt = 1;
                    end else begin
                        m_fresh = 1;
                    end
                    m_single = 0;
                end
            end else if (!m_stall && m_elapsed >= int'(Divisor)) begin
                m_stall = 1;
            end else if (!m_stall) begin
                m_elapsed++;
            end
        end else if (m_halt) begin
            if (!HaltReq && (Step || (Run && !StepMode))) begin
                m_halt = 0; m_run = 1; m_fresh = 1; m_phase = 0; m_elapsed = 0;
                m_single = Step;
            end
        end else if (Run) begin
            m_run = 1; m_fresh = 1; m_phase = 0; m_elapsed = 0;
        end
    endtask

    int dcount;

    initial begin
        Reset = 1; Run = 0; HaltReq = 0; StepMode = 0; Step = 0; MemReady = 1;
        Divisor = 4'd1; LastPhase = 3'd4; MemWaitMask = '0;
        next_cycle();
        next_cycle();

        // rst run div last | ph cs tick done running
        add(1, 0, 1, 4,  0, 4'h0, 0, 0, 0);
        add(0, 1, 1, 4,  0, 4'h0, 0, 0, 0);
        add(0, 1, 1, 4,  0, 4'h0, 1, 0, 1);
        add(0, 1, 1, 4,  0, 4'h0, 0, 0, 1);
        add(0, 1, 1, 4,  1, 4'h1, 1, 0, 1);
        add(0, 1, 1, 4,  1, 4'h1, 0, 0, 1);
        add(0, 1, 1, 4,  2, 4'h3, 1, 0, 1);
        add(0, 1, 1, 4,  2, 4'h3, 0, 0, 1);
        add(0, 1, 1, 4,  3, 4'h7, 1, 0, 1);
        add(0, 1, 1, 4,  3, 4'h7, 0, 0, 1);
        add(0, 1, 1, 4,  4, 4'hF, 1, 0, 1);
        add(0, 1, 1, 4,  4, 4'hF, 0, 1, 1);
        add(0, 1, 0, 2,  0, 4'h0, 1, 0, 1);
        add(0, 1, 0, 2,  1, 4'h1, 1, 0, 1);
        add(0, 1, 0, 2,  2, 4'h3, 1, 1, 1);
        add(0, 1, 0, 2,  0, 4'h0, 1, 0, 1);
        add(0, 1, 0, 2,  1, 4'h1, 1, 0, 1);
        add(0, 1, 0, 2,  2, 4'h3, 1, 1, 1);
        add(0, 1, 0, 7,  0, 4'h0, 1, 0, 1);
        add(0, 1, 0, 7,  1, 4'h1, 1, 0, 1);
        add(0, 1, 0, 7,  2, 4'h3, 1, 0, 1);
        add(0, 1, 0, 7,  3, 4'h7, 1, 0, 1);
        add(0, 1, 0, 7,  4, 4'hF, 1, 1, 1);
        add(0, 1, 0, 7,  0, 4'h0, 1, 0, 1);

        foreach (vq[i]) begin
            next_cycle();
            Reset = vq[i].rst; Run = vq[i].run; Divisor = vq[i].div; LastPhase = vq[i].last;
            settle();
            chk($sformatf("vec%0d_phase", i), 32'(PhaseIndex), 32'(vq[i].e_ph));
            chk($sformatf("vec%0d_onehot", i), 32'(PhaseOneHot),
                vq[i].e_run ? (32'd1 << vq[i].e_ph) : 32'd0);
            chk($sformatf("vec%0d_clksrc", i), 32'(ClockSource), 32'(vq[i].e_cs));
            chk($sformatf("vec%0d_tick", i), 32'(PhaseTick), 32'(vq[i].e_tick));
            chk($sformatf("vec%0d_done", i), 32'(InstrDone), 32'(vq[i].e_done));
            chk($sformatf("vec%0d_running", i), 32'(Running), 32'(vq[i].e_run));
            chk($sformatf("vec%0d_halted", i), 32'(Halted), 32'd0);
        end

        // ---------------- memory stall, then reset during stall ----------------
        next_cycle(); Reset = 1; Run = 0; settle();
        next_cycle(); Reset = 0; Run = 1; Divisor = 0; LastPhase = 4;
        MemWaitMask = 5'b00010; MemReady = 1; settle();
        next_cycle(); settle();
        chk("stall_ph0", 32'(PhaseIndex), 32'd0);
        next_cycle(); MemReady = 0; settle();
        chk("stall_ph1_entry", 32'(PhaseIndex), 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(); settle();
            chk($sformatf("stall_hold%0d_ph", k), 32'(PhaseIndex), 32'd1);
            chk($sformatf("stall_hold%0d_running", k), 32'(Running), 32'd1);
            chk($sformatf("stall_hold%0d_tick", k), 32'(PhaseTick), 32'd0);
            chk($sformatf("stall_hold%0d_done", k), 32'(InstrDone), 32'd0);
        end
        next_cycle(); MemReady = 1; settle();
        chk("stall_exit_ph", 32'(PhaseIndex), 32'd1);
        next_cycle(); MemWaitMask = 5'b01000; settle();
        chk("stall_after_ph", 32'(PhaseIndex), 32'd2);
        chk("stall_after_tick", 32'(PhaseTick), 32'd1);
        next_cycle(); MemReady = 0; settle();
        chk("stall3_entry_ph", 32'(PhaseIndex), 32'd3);
        next_cycle(); settle();
        chk("stall3_ph", 32'(PhaseIndex), 32'd3);
        chk("stall3_running", 32'(Running), 32'd1);
        next_cycle(); Reset = 1; Run = 0; settle();
        chk("stall3_rst_done", 32'(InstrDone), 32'd0);
        next_cycle(); Reset = 0; settle();
        chk("rst_in_stall_outputs",
            32'({PhaseIndex, PhaseOneHot, ClockSource, PhaseTick, InstrDone, Running, Halted}), 32'd0);

        // ---------------- HaltReq honoured at the boundary ----------------
        MemWaitMask = '0; MemReady = 1;
        next_cycle(); Reset = 1; settle();
        next_cycle(); Reset = 0; Run = 1; StepMode = 0; HaltReq = 0; Divisor = 0; LastPhase = 4; settle();
        next_cycle(); settle();
        next_cycle(); settle();
        next_cycle(); HaltReq = 1; settle();
        chk("halt_ph2", 32'(PhaseIndex), 32'd2);
        next_cycle(); settle();
        chk("halt_ph3", 32'(PhaseIndex), 32'd3);
        chk("halt_ph3_done", 32'(InstrDone), 32'd0);
        next_cycle(); settle();
        chk("halt_ph4", 32'(PhaseIndex), 32'd4);
        chk("halt_ph4_done", 32'(InstrDone), 32'd1);
        next_cycle(); settle();
        chk("halt_halted", 32'(Halted), 32'd1);
        chk("halt_running", 32'(Running), 32'd0);
        chk("halt_onehot", 32'(PhaseOneHot), 32'd0);
        chk("halt_tick", 32'(PhaseTick), 32'd0);
        next_cycle(); HaltReq = 0; settle();
        chk("halt_still", 32'(Halted), 32'd1);
        next_cycle(); settle();
        chk("resume_running", 32'(Running), 32'd1);
        chk("resume_ph", 32'(PhaseIndex), 32'd0);
        chk("resume_tick", 32'(PhaseTick), 32'd1);

        // ---------------- StepMode / Step ----------------
        next_cycle(); Reset = 1; Run = 0; settle();
        next_cycle(); Reset = 0; Run = 1; StepMode = 1; settle();
        dcount = 0;
        for (int k = 0; k < 12; k++) begin
            next_cycle(); settle();
            if (InstrDone) dcount++;
        end
        chk("stepmode_done_count", 32'(dcount), 32'd1);
        chk("stepmode_halted", 32'(Halted), 32'd1);
        chk("stepmode_clksrc", 32'(ClockSource), 32'd0);
        next_cycle(); Step = 1; settle();
        dcount = InstrDone ? 1 : 0;
        for (int k = 0; k < 11; k++) begin
            next_cycle(); Step = 0; settle();
            if (InstrDone) dcount++;
        end
        chk("step_done_count", 32'(dcount), 32'd1);
        chk("step_halted", 32'(Halted), 32'd1);
        next_cycle(); Step = 1; HaltReq = 1; settle();
        next_cycle(); Step = 0; settle();
        chk("step_haltreq_halted", 32'(Halted), 32'd1);
        chk("step_haltreq_running", 32'(Running), 32'd0);
        next_cycle(); HaltReq = 0; StepMode = 0; Run = 0; settle();
        chk("step_haltreq_done", 32'(InstrDone), 32'd0);

        // ---------------- randomized against the model ----------------
        next_cycle(); Reset = 1; Run = 0; HaltReq = 0; Step = 0; settle();
        model_on = 0;
        model_step();
        model_on = 1;
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            Reset    = ($urandom_range(0, 199) == 0);
            Run      = ($urandom_range(0, 9) < 7);
            HaltReq  = ($urandom_range(0, 9) == 0);
            StepMode = ($urandom_range(0, 4) == 0);
            Step     = ($urandom_range(0, 9) == 0);
            if (m_elapsed == 0) Divisor = 4'($urandom_range(0, 3));
            LastPhase   = 3'($urandom);
            MemWaitMask = 5'($urandom);
            MemReady    = ($urandom_range(0, 9) < 7);
            settle();
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
